// File: rtl/matmul_pkg.sv
// Shared FSM state type and result-width helper for matrix_mult_seq.
// Signedness is selected at build time by MATMUL_SIGNED_EN (see matmul_mac).
package matmul_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Result element width: full product plus headroom for N accumulations.
    function automatic int unsigned acc_width(input int unsigned n, input int unsigned data_w);
        return (2 * data_w) + int'($clog2(n));
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate unit: one product per enabled cycle, clear loads the first term.
// MATMUL_SIGNED_EN selects two's-complement operands; otherwise operands are unsigned.
module matmul_mac #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  sum
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned EXT_W  = ACC_W - PROD_W;

    logic [PROD_W-1:0] product;
    logic [ACC_W-1:0]  term;

`ifdef MATMUL_SIGNED_EN
    // Sign-extend to the full product width so the truncated product is exact.
    assign product = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    assign term    = {{EXT_W{product[PROD_W-1]}}, product};
`else
    assign product = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    assign term    = {{EXT_W{1'b0}}, product};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (en) begin
            sum <= clear ? term : (sum + term);
        end
    end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential N x N matrix multiplier: load A/B row-major, emit C row-major with valid/ready.
// Operand signedness follows MATMUL_SIGNED_EN (handled inside matmul_mac).
module matrix_mult_seq
    import matmul_pkg::*;
#(
    parameter int unsigned  N      = 4,
    parameter int unsigned  DATA_W = 8,
    localparam int unsigned ACC_W  = acc_width(N, DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned DEPTH  = N * N;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned IDX_W  = $clog2(N + 1);

    state_t            state;
    logic [ADDR_W-1:0] load_cnt;
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic [IDX_W-1:0]  k;

    logic [DATA_W-1:0] a_mem [DEPTH];
    logic [DATA_W-1:0] b_mem [DEPTH];

    logic              load_fire;
    logic              mac_en;
    logic              mac_clear;
    logic [IDX_W-1:0]  k_sel;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [ACC_W-1:0]  acc_sum;

    assign load_fire = (state == LOAD) && in_valid && in_ready;

    // k runs 0..N-1 accumulating; k == N is the cycle that registers the sum.
    assign mac_en    = (state == MAC) && (k != IDX_W'(N));
    assign mac_clear = mac_en && (k == '0);
    assign k_sel     = mac_en ? k : '0;
    assign a_addr    = (ADDR_W'(row) * ADDR_W'(N)) + ADDR_W'(k_sel);
    assign b_addr    = (ADDR_W'(k_sel) * ADDR_W'(N)) + ADDR_W'(col);

    // Operand storage is written only on load handshakes and never reset.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            a_mem[load_cnt] <= in_a;
            b_mem[load_cnt] <= in_b;
        end
    end

    matmul_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (mac_clear),
        .en     (mac_en),
        .a      (a_mem[a_addr]),
        .b      (b_mem[b_addr]),
        .sum    (acc_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            load_cnt  <= '0;
            row       <= '0;
            col       <= '0;
            k         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (load_fire) begin
                        busy <= 1'b1;
                        if (load_cnt == ADDR_W'(DEPTH - 1)) begin
                            load_cnt <= '0;
                            in_ready <= 1'b0;
                            k        <= '0;
                            state    <= MAC;
                        end else begin
                            load_cnt <= load_cnt + ADDR_W'(1);
                        end
                    end
                end
                MAC: begin
                    if (k == IDX_W'(N)) begin
                        out_data  <= acc_sum;
                        out_valid <= 1'b1;
                        out_last  <= (row == IDX_W'(N - 1)) && (col == IDX_W'(N - 1));
                        k         <= '0;
                        state     <= OUT;
                    end else begin
                        k <= k + IDX_W'(1);
                    end
                end
                OUT: begin
                    // Result holds until accepted; column advances first, then row.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (col == IDX_W'(N - 1)) begin
                            col <= '0;
                            if (row == IDX_W'(N - 1)) begin
                                row      <= '0;
                                in_ready <= 1'b1;
                                busy     <= 1'b0;
                                state    <= LOAD;
                            end else begin
                                row   <= row + IDX_W'(1);
                                state <= MAC;
                            end
                        end else begin
                            col   <= col + IDX_W'(1);
                            state <= MAC;
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: doc/matrix_mult_seq.md
MATRIX_MULT_SEQ -- requirements
Module: matrix_mult_seq

Interface
REQ-001 SHALL have parameter N, default 4, matrix dimension (N x N operands, N >= 2).
REQ-002 SHALL have parameter DATA_W, default 8, operand element width.
REQ-003 SHALL derive the localparam ACC_W = 2*DATA_W + $clog2(N), the result element width.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the in_a/in_b beat is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts an operand beat.
REQ-008 SHALL have port in_a, input, DATA_W bits: element A[r][c], row-major order.
REQ-009 SHALL have port in_b, input, DATA_W bits: element B[r][c], same index as in_a.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a result element.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port out_data, output, ACC_W bits: element C[i][j], row-major order.
REQ-013 SHALL have port out_last, output, 1 bit: high with C[N-1][N-1].
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than LOAD with beat count 0.

Function
REQ-015 SHALL implement FSM states LOAD, MAC, OUT.
- LOAD: in_ready=1.
- Each handshake (in_valid & in_ready) writes A and B storage at index r*N+c and increments the load counter.
REQ-016 SHALL move LOAD->MAC on the handshake of beat N*N-1; in_ready SHALL be 0 in the next cycle.
REQ-017 In MAC, the block SHALL accumulate A[i][k]*B[k][j] for k=0..N-1, one product per cycle, with the accumulator cleared at k=0.
REQ-018 SHALL move MAC->OUT after N cycles, registering the sum into out_data with out_valid=1.
- Latency from the last load beat to the first out_valid SHALL be N+1 cycles.
REQ-019 In OUT, out_data and out_valid SHALL hold stable until out_valid & out_ready.
- Then advance j, then i, and return to MAC.
- After C[N-1][N-1] is accepted, return to LOAD with all counters 0.
REQ-020 SHALL produce exactly N*N results per operand set, in order C[0][0]..C[N-1][N-1].
REQ-021 No accumulator overflow: ACC_W SHALL hold N*(2^DATA_W-1)^2 unsigned and N*(-2^(DATA_W-1))^2 signed.
REQ-022 SHALL ignore in_valid outside LOAD.
- No operand storage write outside LOAD.
- A new operand set SHALL NOT be accepted until the previous out_last is accepted.
REQ-023 Deasserting out_ready in OUT SHALL stall the engine indefinitely without data loss.
- out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-024 rst_n low SHALL asynchronously force state LOAD and zero all counters and the accumulator.
- Output values under reset: out_valid=0, out_data=0, out_last=0, busy=0, in_ready=1 once rst_n deasserts.
REQ-025 Reset mid-LOAD, mid-MAC or mid-OUT SHALL discard all partial operands and results.
- Operand storage need not be cleared.

Configuration
REQ-026 Macro MATMUL_SIGNED_EN defined: in_a/in_b SHALL be two's complement and products sign-extended to ACC_W.
- Macro undefined: operands unsigned and zero-extended.

Structure
REQ-027 Package matmul_pkg SHALL hold the state enum type (LOAD/MAC/OUT) and the function computing ACC_W from N and DATA_W.
REQ-028 Sub-module matmul_mac SHALL hold the multiplier-accumulator (clear, enable, operands, ACC_W sum).
- Signedness SHALL follow MATMUL_SIGNED_EN.

Verification
REQ-029 Identity case: N=4, A=I, B[r][c]=r*4+c -> C equals B; out_last on the 16th result only.
REQ-030 Unsigned maximum: A=B=all 255, macro undefined -> every C element = 260100 (ACC_W=18).
REQ-031 Signed case: MATMUL_SIGNED_EN, A=B=all -128 -> every C element = 65536; A=all -1, B=all 1 -> every C element = -4.
REQ-032 Backpressure: out_ready toggled randomly / held low 20 cycles -> out_data stable while stalled, all 16 results correct and in order.
REQ-033 Reset mid-operation: rst_n pulsed low during MAC of C[1][2] -> out_valid=0 immediately, in_ready=1 after release, next full set computed correctly.
REQ-034 Back-to-back sets: in_valid held high across two sets -> in_ready=0 from the last beat until out_last is accepted, second set correct.
